// File: rtl/serial_shift_engine_pkg.sv
// rtl/serial_shift_engine_pkg.sv - shared constants, state encoding and clog2 helper
package serial_shift_engine_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

  localparam int          DEF_WIDTH        = 8;
  localparam logic [31:0] DEF_LOAD_DEFAULT = 32'h0000_00A5;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - bit counter with clear, increment enable and saturation
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clr_i        : synchronous clear (wins over inc_i)
//   inc_i        : increment enable; holds once count reaches WIDTH
//   count_o      : current count
//   terminal_o   : high when the next increment makes count equal WIDTH
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_W'(WIDTH))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_shift_engine.sv
// rtl/serial_shift_engine.sv - framed, direction-selectable shift register with word-done strobe
// Optional macro SERIAL_SHIFT_ENGINE_PARITY_EN adds output parityOdd (XOR of completed word).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   peripheralClkEdge : one-cycle shift strobe
//   parallelLoad      : one-cycle load strobe, starts a word
//   useDefault        : load LOAD_DEFAULT instead of parallelDataIn
//   parallelDataIn    : load value
//   serialDataIn      : bit shifted in per strobe
//   msbFirst          : 1 = shift left, 0 = shift right
//   parallelDataOut   : register contents
//   serialDataOut     : outgoing bit for the active direction
//   bitCount          : bits shifted in the current word
//   busy              : high while in SHIFT
//   parityOdd         : (optional) parity of completed word
//   wordDone          : one-cycle completion pulse
module serial_shift_engine
  import serial_shift_engine_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LOAD_DEFAULT = WIDTH'(DEF_LOAD_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        peripheralClkEdge,
  input  logic                        parallelLoad,
  input  logic                        useDefault,
  input  logic [WIDTH-1:0]            parallelDataIn,
  input  logic                        serialDataIn,
  input  logic                        msbFirst,
  output logic [WIDTH-1:0]            parallelDataOut,
  output logic                        serialDataOut,
  output logic [clog2(WIDTH+1)-1:0]   bitCount,
  output logic                        busy,
`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
  output logic                        parityOdd,
`endif
  output logic                        wordDone
);

  localparam int CNT_W = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_inc, cnt_terminal;
  logic             active_msb;
  logic [WIDTH-1:0] shifted;

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .count_o    (bitCount),
    .terminal_o (cnt_terminal)
  );

  // IDLE follows the live direction input; a word uses the direction captured at load.
  assign active_msb = (state_q == ST_IDLE) ? msbFirst : mode_q;
  assign shifted    = active_msb ? {reg_q[WIDTH-2:0], serialDataIn}
                                 : {serialDataIn, reg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (parallelLoad) begin
      // Load wins over a coincident shift strobe.
      reg_d   = useDefault ? LOAD_DEFAULT : parallelDataIn;
      mode_d  = msbFirst;
      cnt_clr = 1'b1;
      state_d = ST_SHIFT;
    end else if (peripheralClkEdge) begin
      case (state_q)
        ST_IDLE: reg_d = shifted;
        ST_SHIFT: begin
          reg_d   = shifted;
          cnt_inc = 1'b1;
          if (cnt_terminal) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      mode_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (parallelLoad)  par_d = 1'b0;
    else if (done_d)   par_d = ^shifted;
  end

  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign parityOdd = par_q;
`endif

  assign parallelDataOut = reg_q;
  assign serialDataOut   = active_msb ? reg_q[WIDTH-1] : reg_q[0];
  assign busy            = (state_q == ST_SHIFT);
  assign wordDone        = done_q;

endmodule

// File: tb/tb_serial_shift_engine.sv
// tb/tb_serial_shift_engine.sv - scoreboard testbench for serial_shift_engine
module tb_serial_shift_engine;

  logic       clk;
  logic       reset;
  logic       peripheralClkEdge;
  logic       parallelLoad;
  logic       useDefault;
  logic [7:0] parallelDataIn;
  logic       serialDataIn;
  logic       msbFirst;
  logic [7:0] parallelDataOut;
  logic       serialDataOut;
  logic [3:0] bitCount;
  logic       busy;
  logic       wordDone;
`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
  logic       parityOdd;
`endif

  serial_shift_engine #(.WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .peripheralClkEdge (peripheralClkEdge),
    .parallelLoad      (parallelLoad),
    .useDefault        (useDefault),
    .parallelDataIn    (parallelDataIn),
    .serialDataIn      (serialDataIn),
    .msbFirst          (msbFirst),
    .parallelDataOut   (parallelDataOut),
    .serialDataOut     (serialDataOut),
    .bitCount          (bitCount),
    .busy              (busy),
`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
    .parityOdd         (parityOdd),
`endif
    .wordDone          (wordDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       sout;
    logic       par;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;
  int   wd_seen = 0;

  // Reference model state (0 = idle, 1 = shift, 2 = done)
  logic [7:0] m_reg;
  int         m_cnt;
  int         m_state;
  logic       m_mode;
  logic       m_done;
  logic       m_par;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model(input bit rst, input bit ld, input bit ud, input logic [7:0] pd,
                       input bit stb, input bit sin, input bit msb);
    bit dir;
    m_done = 1'b0;
    if (rst) begin
      m_reg = 8'h00; m_cnt = 0; m_state = 0; m_mode = 1'b1; m_par = 1'b0;
    end else if (ld) begin
      m_reg = ud ? 8'hA5 : pd; m_cnt = 0; m_state = 1; m_mode = msb; m_par = 1'b0;
    end else if (stb && m_state != 2) begin
      dir = (m_state == 0) ? msb : m_mode;
      if (dir) m_reg = (m_reg << 1) | {7'd0, sin};
      else     m_reg = (m_reg >> 1) | {sin, 7'd0};
      if (m_state == 1) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
          m_state = 2; m_done = 1'b1;
          m_par = ^m_reg;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit ld, input bit ud, input logic [7:0] pd,
                      input bit stb, input bit sin, input bit msb);
    exp_t e;
    bit   dir;
    @(negedge clk);
    reset = rst; parallelLoad = ld; useDefault = ud; parallelDataIn = pd;
    peripheralClkEdge = stb; serialDataIn = sin; msbFirst = msb;
    model(rst, ld, ud, pd, stb, sin, msb);
    dir    = (m_state == 0) ? msb : m_mode;
    e.data = m_reg;
    e.cnt  = 4'(m_cnt);
    e.busy = (m_state == 1);
    e.done = m_done;
    e.sout = dir ? m_reg[7] : m_reg[0];
    e.par  = m_par;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    chk("dout", 32'(parallelDataOut), 32'(e.data));
    chk("bitcount", 32'(bitCount), 32'(e.cnt));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("worddone", 32'(wordDone), 32'(e.done));
    chk("serialout", 32'(serialDataOut), 32'(e.sout));
`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
    chk("parity", 32'(parityOdd), 32'(e.par));
`endif
    if (wordDone === 1'b1) wd_seen++;
  endtask

  logic [7:0] bits_b3;
  int         wd_start;

  initial begin
    reset = 1'b1; parallelLoad = 1'b0; useDefault = 1'b0; parallelDataIn = 8'h00;
    peripheralClkEdge = 1'b0; serialDataIn = 1'b0; msbFirst = 1'b1;

    // Reset, then default load
    step(1, 0, 0, 8'h00, 0, 0, 1);
    step(0, 1, 1, 8'h3C, 0, 0, 1);
    chk("t1_default", 32'(parallelDataOut), 32'hA5);
    chk("t1_sout", 32'(serialDataOut), 32'h1);

    // MSB-first word 1,0,1,1,0,0,1,1 -> B3, then a ninth ignored strobe
    bits_b3 = 8'b1011_0011;
    wd_start = wd_seen;
    for (int i = 7; i >= 0; i--) step(0, 0, 0, 8'h00, 1, bits_b3[i], 1);
    chk("t2_word", 32'(parallelDataOut), 32'hB3);
    chk("t2_cnt", 32'(bitCount), 32'd8);
`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
    chk("t2_parity", 32'(parityOdd), 32'h1);
`endif
    step(0, 0, 0, 8'h00, 1, 1, 1);
    chk("t2_frozen", 32'(parallelDataOut), 32'hB3);
    chk("t2_pulses", 32'(wd_seen - wd_start), 32'd1);

    // LSB-first word with msbFirst toggled mid-word
    step(0, 1, 0, 8'h01, 0, 0, 0);
`ifdef SERIAL_SHIFT_ENGINE_PARITY_EN
    chk("t3_parclr", 32'(parityOdd), 32'h0);
`endif
    wd_start = wd_seen;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h00, 1, 0, (i >= 2));
    chk("t3_word", 32'(parallelDataOut), 32'h00);
    chk("t3_pulses", 32'(wd_seen - wd_start), 32'd1);

    // Load and strobe together
    step(0, 1, 0, 8'h5A, 1, 1, 1);
    chk("t4_load", 32'(parallelDataOut), 32'h5A);
    chk("t4_cnt0", 32'(bitCount), 32'd0);
    step(0, 0, 0, 8'h00, 1, 0, 1);
    chk("t4_cnt1", 32'(bitCount), 32'd1);

    // Reset mid-word, then free-running IDLE shifts
    step(0, 0, 0, 8'h00, 1, 1, 1);
    step(0, 0, 0, 8'h00, 1, 1, 1);
    step(0, 0, 0, 8'h00, 1, 0, 1);
    chk("t5_cnt4", 32'(bitCount), 32'd4);
    step(1, 0, 0, 8'h00, 1, 1, 1);
    chk("t5_rst", 32'(parallelDataOut), 32'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 1, 1'(i % 3 == 0), 1'(i < 5));
    chk("t5_idlecnt", 32'(bitCount), 32'd0);

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0), 1'($urandom),
           8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/serial_shift_engine.md
Name: serial_shift_engine

Overview:
Parametrised successor to the 8-bit board shift register. Adds a bit counter, word framing, selectable shift direction and a word-complete strobe. Sits between the input conditioners and the LED / serial output logic. Consumes already-conditioned one-cycle strobes (peripheral clock edge, load) and never samples raw switches or buttons.

Parameters:
- WIDTH, 8, shift register width in bits; legal range 2..32.
- LOAD_DEFAULT, 8'hA5 zero-extended to WIDTH, value taken by the register when `useDefault` is high during a load.
- CNT_W, derived localparam = clog2(WIDTH+1), bit-counter width; not user-overridable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- peripheralClkEdge  in  1  one-cycle shift strobe.
- parallelLoad  in  1  one-cycle load strobe; starts a word.
- useDefault  in  1  on load, take LOAD_DEFAULT instead of `parallelDataIn`.
- parallelDataIn  in  WIDTH  load value.
- serialDataIn  in  1  bit shifted in on each strobe.
- msbFirst  in  1  shift direction: 1 = shift left, 0 = shift right.
- parallelDataOut  out  WIDTH  register contents.
- serialDataOut  out  1  outgoing bit: `reg[WIDTH-1]` if the active mode is MSB-first, else `reg[0]`; combinational from the register.
- bitCount  out  CNT_W  bits shifted in the current word.
- busy  out  1  high in SHIFT.
- wordDone  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, highest priority):
  - register 0, bitCount 0, state IDLE, wordDone 0, busy 0, latched mode 1 (MSB-first).
  - Applies mid-word: the next cycle shows all-zero outputs and IDLE.
- States:
  - IDLE: shifts are free-running. Each strobe shifts using the live `msbFirst`. bitCount stays 0; wordDone never fires.
  - SHIFT: counted shifts using the mode latched at load.
  - DONE: register frozen; strobes ignored.
- Transitions:
  - Any state -> SHIFT on `parallelLoad`: register <= `useDefault ? LOAD_DEFAULT : parallelDataIn`; bitCount <= 0; latched mode <= `msbFirst`.
  - SHIFT -> DONE on the strobe that makes bitCount == WIDTH.
  - DONE -> SHIFT only on `parallelLoad`. No automatic return to IDLE.
- Shift operation:
  - MSB-first: reg <= {reg[WIDTH-2:0], serialDataIn}.
  - LSB-first: reg <= {serialDataIn, reg[WIDTH-1:1]}.
- Simultaneous `parallelLoad` and `peripheralClkEdge`: load wins; the strobe is discarded; bitCount = 0.
- Latency: register, bitCount and state update on the clock edge that samples the strobe; results are visible the following cycle.
- wordDone:
  - Registered; high for exactly the single cycle in which `parallelDataOut` first shows the complete word (same cycle state reads DONE).
  - Low otherwise, including after reset and after a load.
- `msbFirst` changes during SHIFT have no effect until the next load.
- bitCount saturates at WIDTH in DONE; it never wraps.

Optional Feature:
- Macro: SERIAL_SHIFT_ENGINE_PARITY_EN.
- Defined:
  - Adds output `parityOdd` (1 bit) = XOR of the completed word.
  - Registered and updated in the same cycle wordDone asserts.
  - Held until the next load or reset, both of which clear it to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package `serial_shift_engine_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - default WIDTH / LOAD_DEFAULT constants;
  - clog2 function.
- One sub-module `shift_bit_counter`:
  - counter with synchronous clear, increment-enable and saturate-at-WIDTH;
  - asserts `terminal` when the next increment reaches WIDTH.
- FSM and datapath stay in the top module.

Test Plan:
- Reset -> load 0x3C with useDefault=1, msbFirst=1 -> parallelDataOut=0xA5, busy=1, bitCount=0, serialDataOut=1.
- After load of 0xA5 MSB-first: 8 strobes with serialDataIn 1,0,1,1,0,0,1,1 -> parallelDataOut=0xB3, bitCount=8, wordDone high one cycle, busy=0. A 9th strobe leaves 0xB3 unchanged.
- Load 0x01 with msbFirst=0, then toggle msbFirst to 1 mid-word; 8 strobes with serialDataIn=0 -> serialDataOut sequence 1,0,0,0,0,0,0,0, final word 0x00, wordDone once.
- Load and strobe in the same cycle with parallelDataIn=0x5A -> parallelDataOut=0x5A, bitCount=0. Next strobe makes bitCount=1.
- Reset asserted at bitCount=4 -> next cycle parallelDataOut=0, bitCount=0, busy=0, no wordDone. Strobes in IDLE shift without counting.
- With SERIAL_SHIFT_ENGINE_PARITY_EN defined, the MSB-first 0xB3 word -> parityOdd=1 in the wordDone cycle. A subsequent load clears it to 0.
